alu_muldiv: RTL

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, sitting in the EX stage beside the single-cycle ALU. It executes MULT, MULTU, DIV, DIVU iteratively (one bit per cycle), handles MTHI/MTLO writes, and exposes HI/LO for MFHI/MFLO. A start/busy/done handshake lets the hazard unit stall the pipeline while an operation is in flight.

---
 rtl/alu_muldiv_pkg.sv | 25 ++
 rtl/alu_muldiv_if.sv | 32 +++
 rtl/alu_muldiv_step.sv | 52 +++++
 rtl/alu_muldiv.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/alu_muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM state encoding and the divide-by-zero result convention.
package alu_muldiv_pkg;

  // Operation codes carried on i_op; any other value is a NOP.
  localparam int OP_MULT  = 0;
  localparam int OP_MULTU = 1;
  localparam int OP_DIV   = 2;
  localparam int OP_DIVU  = 3;
  localparam int OP_MTHI  = 4;
  localparam int OP_MTLO  = 5;

  // Controller states: IDLE waits for work, CALC iterates one bit per
  // cycle, FIX applies sign correction and writes HI/LO.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  // Divide by zero does not trap: every quotient bit is filled with this
  // value (LO = all ones) and HI returns the dividend.
  localparam bit DIV0_QUOT_FILL = 1'b1;

endpackage

// File: rtl/alu_muldiv_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
//
// Handshake: i_start is a single-cycle request that is accepted on a rising
// edge only while o_busy is low and i_flush is low. Once accepted, a MULT/DIV
// holds o_busy high until it completes; the result is announced by a
// one-cycle o_done pulse (o_busy low in that cycle), during which a new
// request may already be accepted. MTHI/MTLO complete at the accepting edge
// with neither o_busy nor o_done. i_flush aborts any operation in flight.
interface alu_muldiv_if #(
  parameter int DATA_SIZE = 32,
  parameter int OP_SIZE   = 3
);
  logic                 i_start;
  logic [OP_SIZE-1:0]   i_op;
  logic [DATA_SIZE-1:0] i_A;
  logic [DATA_SIZE-1:0] i_B;
  logic                 i_flush;
  logic                 o_busy;
  logic                 o_done;
  logic [DATA_SIZE-1:0] o_hi;
  logic [DATA_SIZE-1:0] o_lo;

  modport master (
    output i_start, i_op, i_A, i_B, i_flush,
    input  o_busy, o_done, o_hi, o_lo
  );

  modport slave (
    input  i_start, i_op, i_A, i_B, i_flush,
    output o_busy, o_done, o_hi, o_lo
  );
endinterface

// File: rtl/alu_muldiv_step.sv
// One combinational iteration of the multiply/divide datapath: a shift-add
// step on the 2N-bit product accumulator, or a restoring-division step on
// the remainder/quotient pair. The divide path exists only when HAS_DIV=1.
module alu_muldiv_step #(
  parameter int DATA_SIZE = 32,
  parameter bit HAS_DIV   = 1'b1
) (
  input  logic                   mode_div,
  input  logic [2*DATA_SIZE-1:0] acc,
  input  logic [DATA_SIZE-1:0]   rem,
  input  logic [DATA_SIZE-1:0]   quot,
  input  logic [DATA_SIZE-1:0]   operand,
  output logic [2*DATA_SIZE-1:0] acc_next,
  output logic [DATA_SIZE-1:0]   rem_next,
  output logic [DATA_SIZE-1:0]   quot_next
);
  localparam int N = DATA_SIZE;

  logic [N:0] mul_sum;

  // Shift-add: the multiplier sits in the low half and is consumed LSB
  // first; the multiplicand is added into the high half, then all shifts right.
  always_comb begin
    mul_sum  = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, operand} : {(N+1){1'b0}});
    acc_next = mode_div ? acc : {mul_sum, acc[N-1:1]};
  end

  if (HAS_DIV) begin : g_div
    logic [N:0] shifted;
    logic [N:0] trial;

    // Restoring division: shift the next dividend bit into the remainder
    // and keep the subtraction only when it does not borrow.
    always_comb begin
      shifted = {rem, quot[N-1]};
      trial   = shifted - {1'b0, operand};
      if (trial[N]) begin
        rem_next  = shifted[N-1:0];
        quot_next = {quot[N-2:0], 1'b0};
      end else begin
        rem_next  = trial[N-1:0];
        quot_next = {quot[N-2:0], 1'b1};
      end
    end
  end else begin : g_no_div
    logic unused_div;
    assign unused_div = ^{rem, quot};
    assign rem_next   = '0;
    assign quot_next  = '0;
  end

endmodule

// File: rtl/alu_muldiv.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Operands are reduced to magnitudes at start, iterated one bit per cycle,
// and sign-corrected in a single FIX cycle before HI/LO are written.
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int OP_SIZE   = 3,
  parameter bit HAS_DIV   = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_reset,
  alu_muldiv_if.slave  bus,
  output state_e       dbg_state
);
  localparam int N  = DATA_SIZE;
  localparam int CW = $clog2(DATA_SIZE);

  state_e         state;
  state_e         state_next;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   a_mag;
  logic [N-1:0]   b_mag;
  logic           a_neg;
  logic           b_neg;
  logic           is_div;
  logic [2*N-1:0] acc;
  logic [N-1:0]   rem;
  logic [N-1:0]   quot;
  logic [N-1:0]   hi;
  logic [N-1:0]   lo;
  logic           busy;
  logic           done;

  logic           op_mul;
  logic           op_div;
  logic           op_signed;
  logic           op_mthi;
  logic           op_mtlo;
  logic           accept;
  logic [N-1:0]   a_in_mag;
  logic [N-1:0]   b_in_mag;
  logic [N-1:0]   operand;
  logic [2*N-1:0] acc_next;
  logic [N-1:0]   rem_next;
  logic [N-1:0]   quot_next;
  logic [2*N-1:0] prod_fix;
  logic [N-1:0]   quot_fix;
  logic [N-1:0]   rem_fix;

  // Decode the request and form operand magnitudes for the accepting edge.
  always_comb begin
    op_mul    = (bus.i_op == OP_SIZE'(OP_MULT)) || (bus.i_op == OP_SIZE'(OP_MULTU));
    op_div    = HAS_DIV && ((bus.i_op == OP_SIZE'(OP_DIV)) || (bus.i_op == OP_SIZE'(OP_DIVU)));
    op_signed = (bus.i_op == OP_SIZE'(OP_MULT)) || (bus.i_op == OP_SIZE'(OP_DIV));
    op_mthi   = (bus.i_op == OP_SIZE'(OP_MTHI));
    op_mtlo   = (bus.i_op == OP_SIZE'(OP_MTLO));
    accept    = bus.i_start && !bus.i_flush && (state == ST_IDLE);
    a_in_mag  = (op_signed && bus.i_A[N-1]) ? -bus.i_A : bus.i_A;
    b_in_mag  = (op_signed && bus.i_B[N-1]) ? -bus.i_B : bus.i_B;
  end

  // Next-state logic; a flush abandons CALC or FIX without writing HI/LO.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept && (op_mul || op_div)) state_next = ST_CALC;
      ST_CALC: begin
        if (bus.i_flush)    state_next = ST_IDLE;
        else if (cnt == '0) state_next = ST_FIX;
      end
      ST_FIX:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // The step works on the multiplicand for MULT and on the divisor for DIV.
  assign operand = is_div ? b_mag : a_mag;

  alu_muldiv_step #(
    .DATA_SIZE (DATA_SIZE),
    .HAS_DIV   (HAS_DIV)
  ) u_step (
    .mode_div  (is_div),
    .acc       (acc),
    .rem       (rem),
    .quot      (quot),
    .operand   (operand),
    .acc_next  (acc_next),
    .rem_next  (rem_next),
    .quot_next (quot_next)
  );

  // Sign correction: product and quotient negate on differing signs, the
  // remainder follows the dividend; a zero divisor forces the quotient fill.
  always_comb begin
    prod_fix = (a_neg ^ b_neg) ? -acc : acc;
    quot_fix = (a_neg ^ b_neg) ? -quot : quot;
    if (b_mag == '0) quot_fix = {N{DIV0_QUOT_FILL}};
    rem_fix  = a_neg ? -rem : rem;
  end

  // State register, iteration registers, HI/LO and the registered flags.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      a_mag  <= '0;
      b_mag  <= '0;
      a_neg  <= 1'b0;
      b_neg  <= 1'b0;
      is_div <= 1'b0;
      acc    <= '0;
      rem    <= '0;
      quot   <= '0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != ST_IDLE);
      done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept && (op_mul || op_div)) begin
            a_mag  <= a_in_mag;
            b_mag  <= b_in_mag;
            a_neg  <= op_signed && bus.i_A[N-1];
            b_neg  <= op_signed && bus.i_B[N-1];
            is_div <= op_div;
            cnt    <= CW'(N - 1);
            acc    <= {{N{1'b0}}, b_in_mag};
            rem    <= '0;
            quot   <= a_in_mag;
          end else if (accept && op_mthi) begin
            hi <= bus.i_A;
          end else if (accept && op_mtlo) begin
            lo <= bus.i_A;
          end
        end
        ST_CALC: begin
          if (!bus.i_flush) begin
            acc  <= acc_next;
            rem  <= rem_next;
            quot <= quot_next;
            if (cnt != '0) cnt <= cnt - CW'(1);
          end
        end
        ST_FIX: begin
          if (!bus.i_flush) begin
            if (is_div) begin
              hi <= rem_fix;
              lo <= quot_fix;
            end else begin
              {hi, lo} <= prod_fix;
            end
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_busy = busy;
  assign bus.o_done = done;
  assign bus.o_hi   = hi;
  assign bus.o_lo   = lo;
  assign dbg_state  = state;

endmodule
